// File: rtl/graydec_pkg.sv
// Shared types and constants for the graydec Gray decoder / tracker.
package graydec_pkg;

  localparam int GW = 4;

  typedef enum logic {
    IDLE,
    TRACK
  } state_t;

  localparam logic [GW-1:0] D_UP = 4'd1;
  localparam logic [GW-1:0] D_DN = 4'd15;

endpackage

// File: rtl/gray2bin_4.sv
// Combinational 4-bit reflected-Gray to binary converter.
module gray2bin_4
  import graydec_pkg::*;
(
  input  logic [GW-1:0] gray,
  output logic [GW-1:0] bin
);

  always_comb begin
    bin[GW-1] = gray[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/graydec.sv
// Gray sample decoder with step classification and position tracking.
// Define GRAYDEC_ERRCNT_EN to enable the saturating illegal-jump counter.
module graydec
  import graydec_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [GW-1:0] NGray,
  input  logic          gvalid,
  output logic [GW-1:0] NBin,
  output logic          bvalid,
  output logic          up,
  output logic          dn,
  output logic          step_err,
  output logic [PW-1:0] pos,
  output logic [3:0]    errcnt
);

  state_t        state;
  logic [GW-1:0] prev;
  logic [GW-1:0] bin;
  logic [GW-1:0] d;
  logic          is_hold;
  logic          is_up;
  logic          is_dn;
  logic          is_jump;
  logic          take;

  gray2bin_4 u_dec (
    .gray (NGray),
    .bin  (bin)
  );

  // Step is measured on decoded values, not bit distance
  assign d       = bin - prev;
  assign is_hold = (d == '0);
  assign is_up   = (d == D_UP);
  assign is_dn   = (d == D_DN);
  assign is_jump = !(is_hold || is_up || is_dn);
  assign take    = gvalid && !clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      prev     <= '0;
      NBin     <= '0;
      bvalid   <= 1'b0;
      up       <= 1'b0;
      dn       <= 1'b0;
      step_err <= 1'b0;
      pos      <= '0;
    end else begin
      bvalid   <= 1'b0;
      up       <= 1'b0;
      dn       <= 1'b0;
      step_err <= 1'b0;
      if (clr) begin
        state <= IDLE;
        pos   <= '0;
      end else if (gvalid) begin
        NBin   <= bin;
        prev   <= bin;
        bvalid <= 1'b1;
        if (state == IDLE) begin
          pos   <= PW'(bin);
          state <= TRACK;
        end else begin
          unique case (1'b1)
            is_up: begin
              up  <= 1'b1;
              pos <= pos + 1'b1;
            end
            is_dn: begin
              dn  <= 1'b1;
              pos <= pos - 1'b1;
            end
            is_jump: step_err <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef GRAYDEC_ERRCNT_EN
  logic bump;

  assign bump = take && (state == TRACK) && is_jump;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      errcnt <= '0;
    end else if (bump && errcnt != 4'hF) begin
      errcnt <= errcnt + 1'b1;
    end
  end
`else
  logic unused_take;

  assign unused_take = take;
  assign errcnt      = 4'b0000;
`endif

endmodule

// File: tb/tb_graydec.sv
// Scoreboard bench for graydec: directed plan then random stimulus.
module tb_graydec;

  localparam int PW = 8;

  typedef struct packed {
    logic [3:0]    nbin;
    logic          bvalid;
    logic          up;
    logic          dn;
    logic          err;
    logic [PW-1:0] pos;
    logic [3:0]    ecnt;
  } out_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [3:0]    NGray = '0;
  logic          gvalid = 1'b0;
  logic [3:0]    NBin;
  logic          bvalid;
  logic          up;
  logic          dn;
  logic          step_err;
  logic [PW-1:0] pos;
  logic [3:0]    errcnt;

  graydec #(.PW(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .NGray    (NGray),
    .gvalid   (gvalid),
    .NBin     (NBin),
    .bvalid   (bvalid),
    .up       (up),
    .dn       (dn),
    .step_err (step_err),
    .pos      (pos),
    .errcnt   (errcnt)
  );

  always #5 clk = ~clk;

  out_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference model state
  bit m_first = 1'b1;
  int m_prev  = 0;
  int m_nbin  = 0;
  int m_pos   = 0;
  int m_ecnt  = 0;

  function automatic int enc(int v);
    return v ^ (v >> 1);
  endfunction

  // Decode by searching the Gray sequence for the code
  function automatic int dec(int g);
    for (int i = 0; i < 16; i++) begin
      if (enc(i) == g) return i;
    end
    return 0;
  endfunction

  task automatic drive(bit r, bit c, bit v, int g);
    out_t e;
    int   b;
    int   d;
    @(negedge clk);
    rst_n  = r;
    clr    = c;
    gvalid = v;
    NGray  = 4'(g);
    e = '0;
    if (!r) begin
      m_first = 1'b1;
      m_prev  = 0;
      m_nbin  = 0;
      m_pos   = 0;
      m_ecnt  = 0;
    end else if (c) begin
      m_first = 1'b1;
      m_pos   = 0;
      m_ecnt  = 0;
    end else if (v) begin
      b = dec(g);
      e.bvalid = 1'b1;
      if (m_first) begin
        m_pos   = b;
        m_first = 1'b0;
      end else begin
        d = (b - m_prev + 16) % 16;
        if (d == 1) begin
          e.up  = 1'b1;
          m_pos = (m_pos + 1) % (1 << PW);
        end else if (d == 15) begin
          e.dn  = 1'b1;
          m_pos = (m_pos + (1 << PW) - 1) % (1 << PW);
        end else if (d != 0) begin
          e.err = 1'b1;
`ifdef GRAYDEC_ERRCNT_EN
          if (m_ecnt < 15) m_ecnt++;
`endif
        end
      end
      m_prev = b;
      m_nbin = b;
    end
    e.nbin = 4'(m_nbin);
    e.pos  = PW'(m_pos);
    e.ecnt = 4'(m_ecnt);
    q.push_back(e);
  endtask

  task automatic sample(int g);
    drive(1'b1, 1'b0, 1'b1, g);
  endtask

  // Monitor: outputs are registered, so every cycle presents a result
  initial begin
    out_t e;
    out_t got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = '{NBin, bvalid, up, dn, step_err, pos, errcnt};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL cyc%0d outputs got nbin=%0d bv=%b up=%b dn=%b err=%b pos=%0d ecnt=%0d exp nbin=%0d bv=%b up=%b dn=%b err=%b pos=%0d ecnt=%0d",
                   cyc, got.nbin, got.bvalid, got.up, got.dn, got.err,
                   got.pos, got.ecnt, e.nbin, e.bvalid, e.up, e.dn,
                   e.err, e.pos, e.ecnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    int r;
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    // First sample after reset
    sample(4'b0110);
    drive(1'b1, 1'b0, 1'b0, 0);
    // Consecutive up steps from IDLE
    drive(1'b0, 1'b0, 1'b0, 0);
    sample(4'b0110);
    sample(4'b0111);
    sample(4'b0101);
    // Wrap both directions
    drive(1'b1, 1'b1, 1'b0, 0);
    sample(4'b0000);
    sample(4'b1000);
    sample(4'b0000);
    sample(4'b1000);
    sample(4'b0000);
    // Illegal jump with single-bit change, then resync
    drive(1'b1, 1'b1, 1'b0, 0);
    sample(4'b0000);
    sample(4'b0100);
    sample(4'b1100);
    // clr beats gvalid, next sample reloads
    drive(1'b1, 1'b1, 1'b1, 4'b0010);
    sample(4'b0011);
    drive(1'b1, 1'b0, 1'b0, 0);
    // Saturating error count
    drive(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 18; i++) sample((i % 2 == 0) ? 4'b0000 : 4'b0100);
    drive(1'b1, 1'b1, 1'b1, 4'b0100);
    // Mid-stream reset then fresh start
    sample(4'b0001);
    drive(1'b0, 1'b0, 1'b1, 4'b0011);
    sample(4'b1111);
    sample(4'b1110);
    // Random traffic biased toward legal steps
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        g = enc((m_prev + (($urandom_range(0, 1) == 1) ? 1 : 15)) % 16);
      end else if (r < 70) begin
        g = enc(m_prev);
      end else begin
        g = $urandom_range(0, 15);
      end
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 9) < 7), g);
    end
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
